// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : melody_sequencer
//  Description : Table-driven tone sequencer for the buzzer path. Plays up to
//                DEPTH notes (pitch + duration in 1 ms ticks), with an optional
//                silent gap after each note, one-shot or looping, and a
//                start/stop/busy/done handshake toward the game FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer #(
  parameter  int DEPTH     = 16,
  parameter  int PITCH_W   = 32,
  parameter  int DUR_W     = 16,
  parameter  int GAP_TICKS = 0,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_tick,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [PITCH_W-1:0] i_wr_pitch,
  input  logic [DUR_W-1:0]   i_wr_dur,
  input  logic [ADDR_W:0]    i_len,
  input  logic               i_loop,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_play_en,
  output logic [PITCH_W-1:0] o_pitch,
  output logic               o_busy,
  output logic               o_done,
  output logic [ADDR_W-1:0]  o_note_idx
);

  // Tick counter must hold both a note duration and the gap length.
  localparam int c_gap_w  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int c_tcnt_w = (DUR_W > c_gap_w) ? DUR_W : c_gap_w;

  localparam bit                  c_has_gap  = (GAP_TICKS > 0);
  localparam logic [ADDR_W:0]     c_depth    = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_tcnt_w-1:0] c_gap_last = c_tcnt_w'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_play = 2'd1;
  localparam logic [1:0] c_st_gap  = 2'd2;

  // Note table (not reset; contents survive a reset)
  logic [PITCH_W-1:0] r_tbl_pitch [DEPTH];
  logic [DUR_W-1:0]   r_tbl_dur   [DEPTH];

  // Sequencer state
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W:0]     r_len;
  logic [PITCH_W-1:0]  r_cur_pitch;
  logic [DUR_W-1:0]    r_cur_dur;
  logic [c_tcnt_w-1:0] r_tcnt;

  // Registered outputs
  logic               r_play_en;
  logic [PITCH_W-1:0] r_pitch;
  logic               r_busy;
  logic               r_done;
  logic [ADDR_W-1:0]  r_note_idx;

  // Event decode
  logic                w_start_ok;
  logic                w_stop;
  logic [c_tcnt_w-1:0] w_dur_last;
  logic                w_note_end;
  logic                w_gap_end;
  logic                w_advance;
  logic                w_last;
  logic                w_finish;
  logic                w_load;
  logic [ADDR_W-1:0]   w_load_idx;
  logic [PITCH_W-1:0]  w_load_pitch;
  logic [DUR_W-1:0]    w_load_dur;

  // Next-value output terms
  logic               w_play_en_nxt;
  logic [PITCH_W-1:0] w_pitch_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [ADDR_W-1:0]  w_note_idx_nxt;
  logic [PITCH_W-1:0] w_pitch_src;

  // Start only from IDLE with a non-empty length; a coincident stop cancels it.
  assign w_start_ok = (r_state == c_st_idle) && i_start && !i_stop && (i_len != '0);
  assign w_stop     = (r_state != c_st_idle) && i_stop;

  // cur_dur is never 0 (0 is stored as 1), so this cannot underflow.
  assign w_dur_last = c_tcnt_w'(r_cur_dur) - c_tcnt_w'(1);

  // Boundary events are suppressed by stop so an abort always wins.
  assign w_note_end = (r_state == c_st_play) && i_tick && !i_stop && (r_tcnt == w_dur_last);
  assign w_gap_end  = (r_state == c_st_gap)  && i_tick && !i_stop && (r_tcnt == c_gap_last);
  assign w_advance  = (w_note_end && !c_has_gap) || w_gap_end;

  assign w_last     = ({1'b0, r_idx} == (r_len - (ADDR_W + 1)'(1)));
  assign w_finish   = w_advance && w_last && !i_loop;
  assign w_load     = w_start_ok || (w_advance && !w_finish);

  // Start and loop wrap both restart at entry 0.
  assign w_load_idx   = (w_start_ok || w_last) ? '0 : (r_idx + ADDR_W'(1));
  assign w_load_pitch = r_tbl_pitch[w_load_idx];
  assign w_load_dur   = r_tbl_dur[w_load_idx];

  // Table write port, open in every state
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tbl_pitch[i_wr_addr] <= i_wr_pitch;
      r_tbl_dur[i_wr_addr]   <= i_wr_dur;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_start_ok) begin
          w_state_nxt = c_st_play;
        end
      end
      c_st_play: begin
        if (i_stop) begin
          w_state_nxt = c_st_idle;
        end else if (w_note_end) begin
          if (c_has_gap) begin
            w_state_nxt = c_st_gap;
          end else if (w_finish) begin
            w_state_nxt = c_st_idle;
          end else begin
            w_state_nxt = c_st_play;
          end
        end
      end
      c_st_gap: begin
        if (i_stop) begin
          w_state_nxt = c_st_idle;
        end else if (w_gap_end) begin
          w_state_nxt = w_finish ? c_st_idle : c_st_play;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Note index, length, current note latch and tick counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_len       <= '0;
      r_cur_pitch <= '0;
      r_cur_dur   <= '0;
      r_tcnt      <= '0;
    end else begin
      if (w_stop || w_finish) begin
        r_idx <= '0;
      end else if (w_load) begin
        r_idx       <= w_load_idx;
        r_cur_pitch <= w_load_pitch;
        r_cur_dur   <= (w_load_dur == '0) ? DUR_W'(1) : w_load_dur;
      end

      if (w_start_ok) begin
        r_len <= (i_len > c_depth) ? c_depth : i_len;
      end

      // Counter restarts at every note/gap boundary, so it never wraps.
      if ((r_state == c_st_idle) || w_stop || w_load || w_note_end) begin
        r_tcnt <= '0;
      end else if (i_tick) begin
        r_tcnt <= r_tcnt + c_tcnt_w'(1);
      end
    end
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    w_pitch_src    = w_load ? w_load_pitch : r_cur_pitch;
    w_play_en_nxt  = 1'b0;
    w_pitch_nxt    = '0;
    w_busy_nxt     = (w_state_nxt != c_st_idle);
    w_done_nxt     = w_finish;
    w_note_idx_nxt = '0;
    if (w_state_nxt == c_st_play) begin
      w_play_en_nxt = (w_pitch_src != '0);
      w_pitch_nxt   = w_pitch_src;
    end
    if (w_state_nxt != c_st_idle) begin
      w_note_idx_nxt = w_load ? w_load_idx : r_idx;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_play_en  <= 1'b0;
      r_pitch    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_note_idx <= '0;
    end else begin
      r_play_en  <= w_play_en_nxt;
      r_pitch    <= w_pitch_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_note_idx <= w_note_idx_nxt;
    end
  end

  assign o_play_en  = r_play_en;
  assign o_pitch    = r_pitch;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_note_idx = r_note_idx;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_melody_sequencer
//  Description : Bench for melody_sequencer. Two instances (no gap and a
//                2-tick gap) share one stimulus stream; both are compared every
//                cycle against a tick-countdown reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int PW    = 32;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] wr_pitch = '0;
  logic [DW-1:0] wr_dur = '0;
  logic [AW:0]   len = '0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;

  logic          play_en  [2];
  logic [PW-1:0] pitch    [2];
  logic          busy     [2];
  logic          done     [2];
  logic [AW-1:0] note_idx [2];

  always #5 clk = ~clk;

  melody_sequencer #(.DEPTH(DEPTH), .PITCH_W(PW), .DUR_W(DW), .GAP_TICKS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_pitch(wr_pitch), .i_wr_dur(wr_dur), .i_len(len), .i_loop(loop),
    .i_start(start), .i_stop(stop), .o_play_en(play_en[0]), .o_pitch(pitch[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_note_idx(note_idx[0])
  );

  melody_sequencer #(.DEPTH(DEPTH), .PITCH_W(PW), .DUR_W(DW), .GAP_TICKS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_pitch(wr_pitch), .i_wr_dur(wr_dur), .i_len(len), .i_loop(loop),
    .i_start(start), .i_stop(stop), .o_play_en(play_en[1]), .o_pitch(pitch[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_note_idx(note_idx[1])
  );

  int checks = 0;
  int errors = 0;
  bit tick_all = 1'b1;

  // Reference model: per instance, ticks remaining in the current note or gap
  logic [PW-1:0] t_pitch [DEPTH];
  logic [DW-1:0] t_dur   [DEPTH];
  bit            m_busy  [2];
  bit            m_gap   [2];
  bit            m_done  [2];
  int            m_idx   [2];
  int            m_len   [2];
  int            m_rem   [2];
  logic [PW-1:0] m_pitch [2];
  int            gap_of  [2] = '{0, 2};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_load(input int k, input int i);
    m_idx[k]   = i;
    m_pitch[k] = t_pitch[i];
    m_rem[k]   = (t_dur[i] == 0) ? 1 : int'(t_dur[i]);
    m_gap[k]   = 1'b0;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_gap[k]  = 1'b0;
      m_done[k] = 1'b0;
      m_idx[k]  = 0;
    end
  endfunction

  // Apply one clock edge with the inputs currently on the pins
  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (!m_busy[k]) begin
        if (start && !stop && len != 0) begin
          m_busy[k] = 1'b1;
          m_len[k]  = (int'(len) > DEPTH) ? DEPTH : int'(len);
          m_load(k, 0);
        end
      end else if (stop) begin
        m_busy[k] = 1'b0;
        m_idx[k]  = 0;
      end else if (tick) begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          if (!m_gap[k] && gap_of[k] > 0) begin
            m_gap[k] = 1'b1;
            m_rem[k] = gap_of[k];
          end else if (m_idx[k] + 1 < m_len[k]) begin
            m_load(k, m_idx[k] + 1);
          end else if (loop) begin
            m_load(k, 0);
          end else begin
            m_busy[k] = 1'b0;
            m_idx[k]  = 0;
            m_done[k] = 1'b1;
          end
        end
      end
    end
    if (wr_en) begin
      t_pitch[wr_addr] = wr_pitch;
      t_dur[wr_addr]   = wr_dur;
    end
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("g%0d_play_en", gap_of[k]), 64'(play_en[k]),
               64'(m_busy[k] && !m_gap[k] && m_pitch[k] != 0));
      check_eq($sformatf("g%0d_pitch", gap_of[k]), 64'(pitch[k]),
               (m_busy[k] && !m_gap[k]) ? 64'(m_pitch[k]) : 64'(0));
      check_eq($sformatf("g%0d_busy", gap_of[k]), 64'(busy[k]), 64'(m_busy[k]));
      check_eq($sformatf("g%0d_done", gap_of[k]), 64'(done[k]), 64'(m_done[k]));
      check_eq($sformatf("g%0d_idx", gap_of[k]), 64'(note_idx[k]),
               m_busy[k] ? 64'(m_idx[k]) : 64'(0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    start = 1'b0;
    stop  = 1'b0;
    wr_en = 1'b0;
    tick  = tick_all ? 1'b1 : ($urandom_range(0, 2) == 0);
  endtask

  task automatic wr(input int a, input int p, input int d);
    wr_en    = 1'b1;
    wr_addr  = AW'(a);
    wr_pitch = PW'(p);
    wr_dur   = DW'(d);
    step();
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    while ((m_busy[0] || m_busy[1]) && n < maxc) begin
      step();
      n++;
    end
    check_eq("idle_bound", 64'(busy[0] | busy[1]), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    tick  = 1'b1;

    for (int i = 0; i < DEPTH; i++) wr(i, 0, 1);

    // Three-note one-shot sequence, tick every cycle
    wr(0, 85132, 3);
    wr(1, 42565, 2);
    wr(2, 56818, 1);
    len = 3; loop = 1'b0; start = 1'b1;
    step();
    check_eq("seq_note0", 64'(pitch[0]), 64'd85132);
    repeat (3) step();
    check_eq("seq_note1", 64'(pitch[0]), 64'd42565);
    repeat (2) step();
    check_eq("seq_note2", 64'(pitch[0]), 64'd56818);
    step();
    check_eq("seq_end_busy", 64'(busy[0]), 64'd0);
    check_eq("seq_end_done", 64'(done[0]), 64'd1);
    step();
    check_eq("seq_done_pulse", 64'(done[0]), 64'd0);
    run_idle(60);

    // Gap and rest on the 2-tick-gap instance
    wr(0, 63775, 2);
    wr(1, 0, 2);
    len = 2; start = 1'b1;
    step();
    check_eq("gap_note0", 64'(pitch[1]), 64'd63775);
    repeat (2) step();
    check_eq("gap_silent", 64'(play_en[1]), 64'd0);
    repeat (6) step();
    check_eq("gap_done", 64'(done[1]), 64'd1);
    run_idle(60);

    // Looping, then drop loop during note 1
    len = 2; loop = 1'b1; start = 1'b1;
    cnt = 0;
    for (int n = 0; n < 14; n++) begin
      step();
      cnt += int'(done[0]) + int'(done[1]);
    end
    check_eq("loop_no_done", 64'(cnt), 64'd0);
    for (int n = 0; n < 20 && m_idx[0] != 1; n++) step();
    loop = 1'b0;
    run_idle(60);

    // Stop racing a tick, start with stop in IDLE, zero length
    len = 3; loop = 1'b1; start = 1'b1;
    repeat (2) step();
    stop = 1'b1;
    step();
    check_eq("stop_busy", 64'(busy[0] | busy[1]), 64'd0);
    check_eq("stop_no_done", 64'(done[0] | done[1]), 64'd0);
    start = 1'b1; stop = 1'b1;
    step();
    check_eq("start_stop_idle", 64'(busy[0]), 64'd0);
    len = 0; start = 1'b1;
    step();
    check_eq("len0_ignored", 64'(busy[0]), 64'd0);
    loop = 1'b0;

    // Zero duration plays one tick
    wr(0, 1234, 0);
    len = 1; start = 1'b1;
    step();
    check_eq("dur0_pitch", 64'(pitch[0]), 64'd1234);
    step();
    check_eq("dur0_done", 64'(done[0]), 64'd1);
    run_idle(60);

    // Length above DEPTH clamps to DEPTH notes
    for (int i = 0; i < DEPTH; i++) wr(i, 1000 + i, 1);
    len = 9; start = 1'b1;
    step();
    cnt = 1;
    for (int n = 0; n < 40 && busy[0]; n++) begin
      step();
      if (busy[0]) cnt++;
    end
    check_eq("len9_cycles", 64'(cnt), 64'd8);
    run_idle(100);

    // Write to the playing entry only affects later loads
    wr(0, 500, 5);
    len = 1; start = 1'b1;
    repeat (2) step();
    wr(0, 777, 5);
    check_eq("midnote_write", 64'(pitch[0]), 64'd500);
    run_idle(60);
    start = 1'b1;
    step();
    check_eq("reload_write", 64'(pitch[0]), 64'd777);
    run_idle(60);

    // Asynchronous reset mid-playback, then replay from the preserved table
    wr(1, 2222, 3);
    wr(2, 3333, 2);
    len = 3; loop = 1'b1; start = 1'b1;
    repeat (4) step();
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    check_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    loop = 1'b0; start = 1'b1;
    step();
    check_eq("replay_note0", 64'(pitch[0]), 64'd777);
    run_idle(100);

    // Randomized traffic with sparse ticks
    tick_all = 1'b0;
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        wr_en    = 1'b1;
        wr_addr  = AW'($urandom_range(0, DEPTH - 1));
        wr_pitch = ($urandom_range(0, 3) == 0) ? '0 : PW'($urandom_range(1, 100000));
        wr_dur   = DW'($urandom_range(0, 3));
      end else if (r < 18) begin
        start = 1'b1;
        len   = (AW + 1)'($urandom_range(0, 9));
        loop  = 1'($urandom_range(0, 1));
      end else if (r < 20) begin
        stop = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) loop = ~loop;
      step();
    end
    loop = 1'b0;
    tick_all = 1'b1;
    run_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
